// File: rtl/gmii_frame_gen.sv
// N-channel GMII frame generator: one srdy/drdy command port, per-channel
// preamble/SFD/seeded-payload/IFG sequencer with frame counters.
module gmii_frame_gen #(
   parameter int unsigned NUM_CH  = 4,
   parameter int unsigned CH_W    = 3,
   parameter int unsigned LEN_W   = 11,
   parameter int unsigned MIN_LEN = 64,
   parameter int unsigned MAX_LEN = 1518,
   parameter int unsigned PRE_LEN = 7,
   parameter int unsigned IFG_LEN = 12
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   cmd_srdy,
   output logic                   cmd_drdy,
   input  logic [CH_W-1:0]        cmd_ch,
   input  logic [LEN_W-1:0]       cmd_len,
   input  logic [7:0]             cmd_seed,
   output logic                   cmd_err,
   output logic [NUM_CH-1:0]      gmii_rx_dv,
   output logic [NUM_CH*8-1:0]    gmii_rxd,
   output logic [NUM_CH-1:0]      busy,
   output logic [NUM_CH-1:0]      frame_done,
   output logic [NUM_CH*16-1:0]   frame_count
);

   localparam int unsigned CNT_W = LEN_W;
   localparam int unsigned SEL_W = CH_W + 1;
   localparam logic [7:0]  PRE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE = 8'hD5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_SFD,
      S_DATA,
      S_IFG
   } state_t;

   state_t              state_q [NUM_CH];
   state_t              state_n [NUM_CH];
   logic [CNT_W-1:0]    cnt_q   [NUM_CH];
   logic [CNT_W-1:0]    cnt_n   [NUM_CH];
   logic [LEN_W-1:0]    len_q   [NUM_CH];
   logic [LEN_W-1:0]    len_n   [NUM_CH];
   logic [7:0]          byte_q  [NUM_CH];
   logic [7:0]          byte_n  [NUM_CH];
   logic [7:0]          rxd_q   [NUM_CH];
   logic [7:0]          rxd_n   [NUM_CH];
   logic [15:0]         count_q [NUM_CH];
   logic [15:0]         count_n [NUM_CH];
   logic [NUM_CH-1:0]   dv_q, dv_n;
   logic [NUM_CH-1:0]   busy_q, busy_n;
   logic [NUM_CH-1:0]   done_q, done_n;
   logic                err_q, err_n;

   logic                ch_legal_c;
   logic [NUM_CH-1:0]   sel_c;
   logic                accept_c;
   logic [LEN_W-1:0]    len_clamp_c;

   // Command decode; channel compare is one bit wider so NUM_CH == 2**CH_W works
   always_comb begin
      ch_legal_c = ({1'b0, cmd_ch} < SEL_W'(NUM_CH));
      sel_c      = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         sel_c[k] = ({1'b0, cmd_ch} == SEL_W'(k));
      end
      cmd_drdy = ~ch_legal_c | ~(|(sel_c & busy_q));
      accept_c = cmd_srdy & cmd_drdy;
      if (cmd_len < LEN_W'(MIN_LEN)) begin
         len_clamp_c = LEN_W'(MIN_LEN);
      end else if (cmd_len > LEN_W'(MAX_LEN)) begin
         len_clamp_c = LEN_W'(MAX_LEN);
      end else begin
         len_clamp_c = cmd_len;
      end
   end

   // Per-channel next state; outputs are computed one cycle ahead and registered
   always_comb begin
      err_n = cmd_srdy & ~ch_legal_c;
      dv_n   = '0;
      done_n = '0;
      busy_n = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         state_n[k] = state_q[k];
         cnt_n[k]   = cnt_q[k];
         len_n[k]   = len_q[k];
         byte_n[k]  = byte_q[k];
         rxd_n[k]   = 8'h00;
         count_n[k] = count_q[k];
         unique case (state_q[k])
            S_IDLE: begin
               if (accept_c && sel_c[k]) begin
                  state_n[k] = S_PRE;
                  cnt_n[k]   = '0;
                  len_n[k]   = len_clamp_c;
                  byte_n[k]  = cmd_seed;
                  dv_n[k]    = 1'b1;
                  rxd_n[k]   = PRE_BYTE;
               end
            end
            S_PRE: begin
               dv_n[k] = 1'b1;
               if (cnt_q[k] == CNT_W'(PRE_LEN - 1)) begin
                  state_n[k] = S_SFD;
                  rxd_n[k]   = SFD_BYTE;
               end else begin
                  cnt_n[k] = cnt_q[k] + CNT_W'(1);
                  rxd_n[k] = PRE_BYTE;
               end
            end
            S_SFD: begin
               state_n[k] = S_DATA;
               cnt_n[k]   = '0;
               dv_n[k]    = 1'b1;
               rxd_n[k]   = byte_q[k];
               byte_n[k]  = byte_q[k] + 8'd1;
            end
            S_DATA: begin
               if (cnt_q[k] == len_q[k] - CNT_W'(1)) begin
                  state_n[k] = S_IFG;
                  cnt_n[k]   = '0;
                  done_n[k]  = 1'b1;
                  count_n[k] = count_q[k] + 16'd1;
               end else begin
                  cnt_n[k]  = cnt_q[k] + CNT_W'(1);
                  dv_n[k]   = 1'b1;
                  rxd_n[k]  = byte_q[k];
                  byte_n[k] = byte_q[k] + 8'd1;
               end
            end
            S_IFG: begin
               if (cnt_q[k] == CNT_W'(IFG_LEN - 1)) begin
                  state_n[k] = S_IDLE;
               end else begin
                  cnt_n[k] = cnt_q[k] + CNT_W'(1);
               end
            end
            default: state_n[k] = S_IDLE;
         endcase
         busy_n[k] = (state_n[k] != S_IDLE);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < NUM_CH; k++) begin
            state_q[k] <= S_IDLE;
            cnt_q[k]   <= '0;
            len_q[k]   <= '0;
            byte_q[k]  <= '0;
            rxd_q[k]   <= '0;
            count_q[k] <= '0;
         end
         dv_q   <= '0;
         busy_q <= '0;
         done_q <= '0;
         err_q  <= 1'b0;
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            state_q[k] <= state_n[k];
            cnt_q[k]   <= cnt_n[k];
            len_q[k]   <= len_n[k];
            byte_q[k]  <= byte_n[k];
            rxd_q[k]   <= rxd_n[k];
            count_q[k] <= count_n[k];
         end
         dv_q   <= dv_n;
         busy_q <= busy_n;
         done_q <= done_n;
         err_q  <= err_n;
      end
   end

   assign gmii_rx_dv = dv_q;
   assign busy       = busy_q;
   assign frame_done = done_q;
   assign cmd_err    = err_q;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_pack
      assign gmii_rxd[8*k +: 8]     = rxd_q[k];
      assign frame_count[16*k +: 16] = count_q[k];
   end

endmodule

// File: tb/tb_gmii_frame_gen.sv
// Scoreboard bench for gmii_frame_gen: commands push expected bytes, start,
// done and error cycles; a negedge monitor pops and compares.
module tb_gmii_frame_gen;

   localparam int unsigned NUM_CH = 4;
   localparam int unsigned CH_W   = 3;
   localparam int unsigned LEN_W  = 11;

   logic                  clk = 1'b0;
   logic                  reset_n;
   logic                  cmd_srdy;
   logic                  cmd_drdy;
   logic [CH_W-1:0]       cmd_ch;
   logic [LEN_W-1:0]      cmd_len;
   logic [7:0]            cmd_seed;
   logic                  cmd_err;
   logic [NUM_CH-1:0]     gmii_rx_dv;
   logic [NUM_CH*8-1:0]   gmii_rxd;
   logic [NUM_CH-1:0]     busy;
   logic [NUM_CH-1:0]     frame_done;
   logic [NUM_CH*16-1:0]  frame_count;

   gmii_frame_gen dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .cmd_srdy    (cmd_srdy),
      .cmd_drdy    (cmd_drdy),
      .cmd_ch      (cmd_ch),
      .cmd_len     (cmd_len),
      .cmd_seed    (cmd_seed),
      .cmd_err     (cmd_err),
      .gmii_rx_dv  (gmii_rx_dv),
      .gmii_rxd    (gmii_rxd),
      .busy        (busy),
      .frame_done  (frame_done),
      .frame_count (frame_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   logic [7:0]  exp_byte  [NUM_CH][$];
   int          exp_start [NUM_CH][$];
   int          exp_done  [NUM_CH][$];
   int          exp_cnt   [NUM_CH][$];
   int          exp_err   [$];
   logic [15:0] mcount    [NUM_CH];
   logic [NUM_CH-1:0] prev_dv = '0;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h cyc=%0d", name, got, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s cyc=%0d", name, cyc);
   endtask

   function automatic int clamp(input int len);
      if (len < 64)   return 64;
      if (len > 1518) return 1518;
      return len;
   endfunction

   function automatic int pending();
      int n = exp_err.size();
      for (int k = 0; k < NUM_CH; k++)
         n += exp_byte[k].size() + exp_start[k].size() + exp_done[k].size();
      return n;
   endfunction

   // Monitor: every presented byte, frame start, done pulse and error pulse is popped and compared
   always @(negedge clk) begin
      if (reset_n) begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (gmii_rx_dv[k] && !prev_dv[k]) begin
               if (exp_start[k].size() == 0) fail_now($sformatf("unexpected_start ch%0d", k));
               else chk($sformatf("start_cyc ch%0d", k), cyc, exp_start[k].pop_front());
            end
            if (gmii_rx_dv[k]) begin
               if (exp_byte[k].size() == 0) fail_now($sformatf("unexpected_dv ch%0d", k));
               else chk($sformatf("rxd ch%0d", k), int'(gmii_rxd[8*k +: 8]), int'(exp_byte[k].pop_front()));
            end else if (gmii_rxd[8*k +: 8] != 8'h00) begin
               fail_now($sformatf("rxd_nonzero_idle ch%0d", k));
            end
            if (frame_done[k]) begin
               if (exp_done[k].size() == 0) fail_now($sformatf("unexpected_done ch%0d", k));
               else begin
                  chk($sformatf("done_cyc ch%0d", k), cyc, exp_done[k].pop_front());
                  chk($sformatf("frame_count ch%0d", k), int'(frame_count[16*k +: 16]),
                      exp_cnt[k].pop_front());
               end
            end
         end
         if (cmd_err) begin
            if (exp_err.size() == 0) fail_now("unexpected_cmd_err");
            else chk("cmd_err_cyc", cyc, exp_err.pop_front());
         end
      end
      prev_dv <= gmii_rx_dv;
   end

   // Issue one command; returns the accept cycle and pushes the expected response
   task automatic send(input int ch, input int len, input int seed, output int t);
      bit ok = 0;
      int l;
      t = -1;
      cmd_ch   = CH_W'(ch);
      cmd_len  = LEN_W'(len);
      cmd_seed = 8'(seed);
      cmd_srdy = 1'b1;
      for (int w = 0; w < 3000 && !ok; w++) begin
         @(negedge clk);
         if (cmd_drdy) begin
            ok = 1;
            t  = cyc;
            if (ch >= int'(NUM_CH)) begin
               exp_err.push_back(t + 1);
            end else begin
               l = clamp(len);
               exp_start[ch].push_back(t + 1);
               for (int i = 0; i < 7; i++) exp_byte[ch].push_back(8'h55);
               exp_byte[ch].push_back(8'hD5);
               for (int i = 0; i < l; i++) exp_byte[ch].push_back(8'(seed + i));
               exp_done[ch].push_back(t + l + 9);
               mcount[ch] = mcount[ch] + 16'd1;
               exp_cnt[ch].push_back(int'(mcount[ch]));
            end
         end
         @(posedge clk);
         #1;
      end
      cmd_srdy = 1'b0;
      if (!ok) fail_now($sformatf("cmd_accept_timeout ch%0d", ch));
   endtask

   task automatic wait_cyc(input int n);
      for (int w = 0; w < 5000; w++) begin
         @(negedge clk);
         if (cyc >= n) break;
      end
      if (cyc != n) fail_now($sformatf("wait_cyc_missed target=%0d", n));
   endtask

   task automatic drain();
      int w = 0;
      while (pending() != 0 && w < 4000) begin
         @(posedge clk);
         w++;
      end
      chk("drain_pending", pending(), 0);
      repeat (16) @(posedge clk);
      #1;
      chk("drain_busy", int'(busy), 0);
   endtask

   int t0, t1, t2, t3;
   int ts [NUM_CH];

   initial begin
      #500000;
      $display("FAIL watchdog_timeout cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n  = 1'b0;
      cmd_srdy = 1'b0;
      cmd_ch   = '0;
      cmd_len  = '0;
      cmd_seed = '0;
      for (int k = 0; k < NUM_CH; k++) mcount[k] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_dv", int'(gmii_rx_dv), 0);
      chk("rst_rxd", int'(gmii_rxd), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(frame_done), 0);
      chk("rst_err", int'(cmd_err), 0);
      chk("rst_count", int'(frame_count[31:0]), 0);
      chk("rst_count_hi", int'(frame_count[63:32]), 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(negedge clk);
      chk("idle_drdy", int'(cmd_drdy), 1);
      @(posedge clk);
      #1;

      // Single 64-byte frame on ch0, occupancy boundary
      send(0, 64, 8'h10, t0);
      wait_cyc(t0 + 84);
      chk("busy_last_ifg", int'(busy[0]), 1);
      chk("drdy_last_ifg", int'(cmd_drdy), 0);
      @(negedge clk);
      chk("busy_first_idle", int'(busy[0]), 0);
      chk("drdy_first_idle", int'(cmd_drdy), 1);
      @(posedge clk);
      #1;
      drain();

      // Back-to-back ch0 command held from T+1 waits the full occupancy
      send(0, 64, 8'h20, t2);
      send(0, 64, 8'h30, t3);
      chk("b2b_accept_cyc", t3, t2 + 85);
      drain();

      // Length clamping and seed wrap
      send(1, 10, 8'h00, t1);
      send(1, 2000, 8'hAA, t1);
      send(2, 64, 8'hF0, t1);
      drain();

      // Four channels on consecutive cycles
      for (int k = 0; k < NUM_CH; k++) send(k, 64 + k, 8'h40 * k, ts[k]);
      for (int k = 1; k < NUM_CH; k++) chk($sformatf("multi_accept ch%0d", k), ts[k], ts[0] + k);
      drain();

      // Illegal channel is accepted and flagged, no frame, counts unchanged
      send(5, 64, 8'h00, t1);
      drain();
      chk("illegal_count0", int'(frame_count[15:0]), int'(mcount[0]));
      chk("illegal_count2", int'(frame_count[47:32]), int'(mcount[2]));

      // Asynchronous reset mid-DATA on ch2
      send(2, 200, 8'h00, t1);
      wait_cyc(t1 + 59);
      chk("pre_reset_dv2", int'(gmii_rx_dv[2]), 1);
      #2;
      reset_n = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         exp_byte[k].delete();
         exp_start[k].delete();
         exp_done[k].delete();
         exp_cnt[k].delete();
         mcount[k] = '0;
      end
      exp_err.delete();
      #1;
      chk("mid_rst_dv", int'(gmii_rx_dv), 0);
      chk("mid_rst_rxd", int'(gmii_rxd), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_count", int'(frame_count[63:32]), 0);
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      send(2, 64, 8'h10, t1);
      drain();
      chk("post_rst_count2", int'(frame_count[47:32]), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
